uart_rx: RTL and testbench

- UART receiver, 8N1 framing (1 start, 8 data LSB first, ≥1 stop), no parity.
- Receiving counterpart to the design's UART transmitter. Sits between the board RX pin and game/control logic.
- Oversamples the line with the system clock and centre-samples each bit.
- Delivers each byte with a one-cycle valid strobe and flags framing errors.

---
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (1 start, 8 data LSB first, >=1 stop, no parity).
// The line is oversampled with clk and each bit is sampled at its centre.
// Each good byte is reported with a one-cycle rx_valid pulse. A stop bit
// sampled low gives a one-cycle rx_frame_err pulse instead.
// Optional build macro UART_RX_MAJORITY_EN: when it is defined, every
// sample decision is the 2-of-3 majority of the last three synchronised
// samples. This rejects a single-cycle glitch at the sample point.
module uart_rx #(
    parameter int BAUDRATE = 115200,
    parameter int CLK_RATE = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    // Derived bit timing; not meant to be overridden.
    localparam int BAUD_DIV = CLK_RATE / BAUDRATE;
    localparam int HALF     = BAUD_DIV / 2;
    localparam logic [31:0] BAUD_LAST = 32'(BAUD_DIV - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // 2-of-3 majority vote.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    logic [1:0]  state_r;
    logic [31:0] clk_cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        rx_frame_err_r;
    logic        sample_bit_s;

`ifdef UART_RX_MAJORITY_EN
    logic        rx_prev2_r;

    // Extra history flop so the vote spans three consecutive samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev2_r <= 1'b1;
        end else begin
            rx_prev2_r <= rx_prev_r;
        end
    end

    // Sample decision: majority of the current and two previous samples.
    always_comb begin
        sample_bit_s = 1'b1;
        sample_bit_s = majority3(rx_sync_r, rx_prev_r, rx_prev2_r);
    end
`else
    // Sample decision: the single synchronised sample.
    always_comb begin
        sample_bit_s = 1'b1;
        sample_bit_s = rx_sync_r;
    end
`endif

    // Two-flop synchroniser on the asynchronous line, plus a delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Frame FSM: detect start, centre-sample 8 data bits and the stop bit, strobe the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            clk_cnt_r      <= 32'd0;
            bit_idx_r      <= 3'd0;
            shift_r        <= 8'd0;
            rx_data_r      <= 8'd0;
            rx_valid_r     <= 1'b0;
            rx_frame_err_r <= 1'b0;
        end else begin
            rx_valid_r     <= 1'b0;
            rx_frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A fresh falling edge is required, so a held-low line (break) cannot retrigger.
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r   <= START;
                        clk_cnt_r <= 32'd0;
                    end
                end
                START: begin
                    if (clk_cnt_r == HALF_LAST) begin
                        clk_cnt_r <= 32'd0;
                        if (!sample_bit_s) begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            // Line went high again before mid-start: treat as a glitch.
                            state_r <= IDLE;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 32'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt_r == BAUD_LAST) begin
                        clk_cnt_r <= 32'd0;
                        shift_r   <= {sample_bit_s, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 32'd1;
                    end
                end
                STOP: begin
                    // Return to IDLE at mid-stop so a start bit right after a 1-bit stop is caught.
                    if (clk_cnt_r == BAUD_LAST) begin
                        clk_cnt_r <= 32'd0;
                        state_r   <= IDLE;
                        if (sample_bit_s) begin
                            rx_data_r  <= shift_r;
                            rx_valid_r <= 1'b1;
                        end else begin
                            rx_frame_err_r <= 1'b1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clk_cnt_r <= 32'd0;
                end
            endcase
        end
    end

    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign rx_frame_err = rx_frame_err_r;
    assign rx_busy      = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus random frames, scored
// against a frame-level reference model.
module tb_uart_rx;

    localparam int BIT = 434;
    localparam int LAT = 4126;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_valid = 0;
    int n_err   = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         t0;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_last = 8'd0;

    uart_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: the byte the receiver should deliver for a frame. An optional
    // one-cycle glitch sits at the centre of bit glitch_bit. Majority voting
    // rejects it; a single-sample build takes the inverted bit.
    function automatic logic [7:0] model_byte(input logic [7:0] d, input int glitch_bit);
        logic [7:0] m;
        m = 8'd0;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 0) m = 8'd1 << glitch_bit;
`endif
        return d ^ m;
    endfunction

    // Scoreboard: every strobe must match the next expected outcome, in order and on time.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || rx_frame_err)) begin
            exp_t e;
            int   lat;
            check_eq("exclusive", 32'(rx_valid & rx_frame_err), 32'd0);
            if (rx_valid) n_valid++;
            else n_err++;
            check_eq("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                lat = cyc - e.t0;
                check_eq("kind_err", 32'(rx_frame_err), 32'(e.is_err));
                check_eq("data", 32'(rx_data), 32'(e.data));
                if (lat < LAT - 2 || lat > LAT + 2)
                    check_eq("latency", 32'(lat), 32'(LAT));
                else
                    check_eq("latency_window", 32'd1, 32'(lat >= LAT - 2 && lat <= LAT + 2));
            end
        end
    end

    // Drive one frame. The caller must be aligned to a negedge. The stop
    // level is held for stop_cycles, then the line returns high.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                              input int stop_cycles, input int glitch_bit);
        exp_t e;
        rx = 1'b0;
        e.t0 = cyc;
        if (stop_lvl) begin
            model_last = model_byte(d, glitch_bit);
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.data = model_last;
        exp_q.push_back(e);
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == glitch_bit) begin
                repeat (BIT / 2) @(negedge clk);
                rx = ~d[i];
                @(negedge clk);
                rx = d[i];
                repeat (BIT - BIT / 2 - 1) @(negedge clk);
            end else if (i == 4) begin
                repeat (BIT / 2) @(negedge clk);
                check_eq("busy_mid", 32'(rx_busy), 32'd1);
                repeat (BIT - BIT / 2) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        rx = stop_lvl;
        repeat (stop_cycles) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        int         idle_bad;
        logic [7:0] d;
        logic [7:0] prev_data;
        int         v0;
        int         e0;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("reset_data", 32'(rx_data), 32'd0);
        check_eq("reset_busy", 32'(rx_busy), 32'd0);
        rst_n = 1'b1;

        // Idle line: nothing happens.
        idle_bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (rx_valid || rx_frame_err || rx_busy) idle_bad++;
        end
        check_eq("idle_quiet", 32'(idle_bad), 32'd0);
        check_eq("idle_data", 32'(rx_data), 32'd0);

        // Single byte 0xA5.
        send_frame(8'hA5, 1'b1, BIT, -1);
        check_eq("a5_count", 32'(n_valid), 32'd1);
        check_eq("a5_data", 32'(rx_data), 32'hA5);

        // Back-to-back with single stop bits.
        send_frame(8'h00, 1'b1, BIT, -1);
        send_frame(8'hFF, 1'b1, BIT, -1);
        send_frame(8'h55, 1'b1, BIT, -1);
        repeat (200) @(negedge clk);
        check_eq("b2b_count", 32'(n_valid), 32'd4);
        check_eq("b2b_errs", 32'(n_err), 32'd0);
        check_eq("b2b_last", 32'(rx_data), 32'h55);

        // Bad stop bit followed by a break of two frame times.
        send_frame(8'h3C, 1'b0, BIT + 20 * BIT, -1);
        repeat (200) @(negedge clk);
        check_eq("break_errs", 32'(n_err), 32'd1);
        check_eq("break_valid", 32'(n_valid), 32'd4);
        check_eq("break_data", 32'(rx_data), 32'h55);

        // False start: a 100-cycle low pulse.
        v0 = n_valid;
        e0 = n_err;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("glitch_start_busy", 32'(rx_busy), 32'd0);
        check_eq("glitch_start_strobes", 32'(n_valid + n_err), 32'(v0 + e0));

        // Reset in the middle of the data bits of 0xC3.
        d = 8'hC3;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        check_eq("pre_reset_busy", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_data", 32'(rx_data), 32'd0);
        check_eq("midrst_busy", 32'(rx_busy), 32'd0);
        check_eq("midrst_strobe", 32'(rx_valid | rx_frame_err), 32'd0);
        model_last = 8'd0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check_eq("post_rst_strobes", 32'(n_valid + n_err), 32'(v0 + e0));

        // Full frame after the reset.
        send_frame(8'h81, 1'b1, BIT, -1);
        check_eq("after_rst_data", 32'(rx_data), 32'h81);

        // One-cycle glitch at the centre of bit 3 of 0x00.
        send_frame(8'h00, 1'b1, BIT, 3);
        check_eq("glitch_bit3", 32'(rx_data), 32'(model_byte(8'h00, 3)));

        // Random frames: random data, stop length, occasional bad stop, random gaps.
        for (int k = 0; k < 3; k++) begin
            logic bad;
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            prev_data = model_last;
            send_frame(d, ~bad, BIT * $urandom_range(1, 2), -1);
            if (bad) repeat (BIT) @(negedge clk);
            repeat ($urandom_range(0, 200)) @(negedge clk);
            check_eq("rand_data", 32'(rx_data), bad ? 32'(prev_data) : 32'(d));
        end

        repeat (200) @(negedge clk);
        check_eq("all_expected_seen", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
